difftest_commit_seq: RTL
========================

// Module: difftest_commit_seq
// PURPOSE
//  Sequences retired-instruction records from the NPC commit stage to the difftest/trace sink that samples the architectural register snapshot.
//  Buffers commits in a FIFO and presents one record per handshake to the sink.
//  Back-pressures the core when the FIFO is full, and orders the ebreak halt so that it is signalled only after every older commit has drained.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  XLEN    64  data/pc width
// PORTS
//  clock         in   1     core clock, all state on rising edge
//  reset_n       in   1     asynchronous, active-low reset
//  cmt_valid     in   1     commit record offered this cycle
//  cmt_ready     out  1     record accepted when cmt_valid && cmt_ready
//  cmt_pc        in   XLEN  pc of retired instruction
//  cmt_inst      in   32    instruction word
//  cmt_rd        in   5     destination register index
//  cmt_wen       in   1     rd written; forced 0 in record when cmt_rd==0
//  cmt_wdata     in   XLEN  value written to rd
//  cmt_skip      in   1     MMIO access, sink must copy DUT state, not compare
//  cmt_halt      in   1     instruction is ebreak
//  trc_valid     out  1     record at FIFO head valid
//  trc_ready     in   1     sink consumes head when trc_valid && trc_ready
//  trc_pc/inst/rd/wen/wdata/skip  out  as cmt_*  head record fields
//  halt_done     out  1     sticky: halt commit consumed, FIFO empty
//  instr_cnt     out  XLEN  number of records consumed by sink
//  occupancy     out  $clog2(DEPTH)+1  current FIFO fill
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - FIFO empty, state=RUN.
//   - trc_valid=0, cmt_ready=1, halt_done=0, instr_cnt=0, occupancy=0.
//   - trc_* data fields are 0.
//  FIFO:
//   - wr/rd pointers are log2(DEPTH)+1 bits; full = same index with MSBs differing; empty = pointers equal.
//   - Pointers wrap modulo 2*DEPTH.
//   - Record stored at accept edge; trc_* visible the next cycle (1-cycle latency when empty). No same-cycle bypass.
//   - trc_* registered from head entry, stable while trc_valid && !trc_ready.
//  cmt_ready = (state==RUN) && !full.
//  Full and trc_ready in the same cycle:
//   - cmt_ready stays 0 that cycle; no combinational ready path from the sink.
//  Push and pop in the same cycle:
//   - Both take effect; occupancy is unchanged.
//   - Legal at any occupancy except push when full (blocked by cmt_ready).
//  instr_cnt increments by 1 per consumed record; wraps at 2^XLEN.
//  State machine:
//   - RUN -> DRAIN when a record with cmt_halt=1 is accepted. That record is the last one accepted.
//   - DRAIN: cmt_ready=0, FIFO keeps draining.
//   - DRAIN -> HALTED on the cycle the halt record is consumed; FIFO is necessarily empty then.
//   - HALTED: halt_done=1, cmt_ready=0, trc_valid=0. Only reset exits HALTED.
//  Halt record accepted while older records are still queued:
//   - They drain in order first; halt_done never precedes their consumption.
//  Reset mid-operation (any state):
//   - Queued records are discarded, not delivered; outputs return to reset values.
//  cmt_valid while cmt_ready=0:
//   - Ignored; the core must hold the record until accepted.
//  The design never drops or reorders records.
// STRUCTURE
//  Shared package npc_trace_pkg:
//   - typedef commit_rec_t {pc, inst, rd, wen, wdata, skip, halt}.
//   - localparams RV_EBREAK=32'h0010_0073, NREG=32.
//  Sub-module trace_fifo:
//   - Parameterised sync FIFO of commit_rec_t, exposing full/empty/count.
//  Top-level difftest_commit_seq holds the state FSM, ready gating and instr_cnt.
// TESTING
//  1 Reset: hold reset_n=0 -> cmt_ready=1, trc_valid=0, occupancy=0, instr_cnt=0, halt_done=0.
//  2 Single commit: pc=0x80000000, rd=5, wen=1, wdata=0x1234, trc_ready=1
//    -> trc_valid next cycle with the same fields; instr_cnt=1 after the handshake.
//  3 Full: DEPTH=4, trc_ready=0, push 5 commits -> cmt_ready=0 after 4th.
//    Pulse trc_ready for 1 cycle -> head popped, 5th accepted next cycle, order preserved.
//  4 rd=0 with wen=1, wdata=0xdead -> trc_wen=0, trc_rd=0.
//  5 Halt drain: 2 queued commits then ebreak (halt=1), trc_ready toggling
//    -> cmt_ready=0 after halt accept; halt_done rises the cycle after the 3rd pop; instr_cnt=3.
//  6 Reset mid-DRAIN with 3 entries queued -> trc_valid=0 immediately (async); after release, state=RUN, no stale record.

Source files
------------

// File: rtl/difftest_commit_seq_pkg.sv
// rtl/difftest_commit_seq_pkg.sv - shared commit record type and trace constants
package npc_trace_pkg;

    localparam int          REC_XLEN  = 64;
    localparam logic [31:0] RV_EBREAK = 32'h0010_0073;
    localparam int          NREG      = 32;

    // One retired instruction as seen by the difftest sink
    typedef struct packed {
        logic [REC_XLEN-1:0]     pc;
        logic [31:0]             inst;
        logic [$clog2(NREG)-1:0] rd;
        logic                    wen;
        logic [REC_XLEN-1:0]     wdata;
        logic                    skip;
        logic                    halt;
    } commit_rec_t;

    typedef enum logic [1:0] {
        SEQ_RUN,
        SEQ_DRAIN,
        SEQ_HALTED
    } seq_state_e;

    // x0 is hardwired, so a write to it must never reach the sink as a write
    function automatic logic rd_writes(input logic wen, input logic [$clog2(NREG)-1:0] rd);
        return wen && (rd != '0);
    endfunction

endpackage

// File: rtl/difftest_commit_seq_if.sv
// rtl/difftest_commit_seq_if.sv - valid/ready commit record stream
interface commit_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic            skip;
    logic            halt;

    modport master (output valid, pc, inst, rd, wen, wdata, skip, halt, input ready);
    modport slave  (input valid, pc, inst, rd, wen, wdata, skip, halt, output ready);
endinterface

// File: rtl/difftest_commit_seq_trace_fifo.sv
// rtl/difftest_commit_seq_trace_fifo.sv - synchronous FIFO of commit records
module trace_fifo
    import npc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  commit_rec_t            wr_data,
    input  logic                   pop,
    output commit_rec_t            rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    commit_rec_t mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Head is read straight from storage flops, so it holds until popped
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/difftest_commit_seq.sv
// rtl/difftest_commit_seq.sv - commit-to-difftest sequencer with ordered ebreak halt
module difftest_commit_seq
    import npc_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    commit_if.slave                cmt,
    commit_if.master               trc,
    output logic                   halt_done,
    output logic [XLEN-1:0]        instr_cnt,
    output logic [$clog2(DEPTH):0] occupancy
);
    seq_state_e  state;
    commit_rec_t wr_rec;
    commit_rec_t head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    // Ready depends only on state and fill, never on the sink's ready
    assign cmt.ready = (state == SEQ_RUN) && !full;
    assign trc.valid = !empty && (state != SEQ_HALTED);
    assign push      = cmt.valid && cmt.ready;
    assign pop       = trc.valid && trc.ready;

    assign wr_rec.pc    = REC_XLEN'(cmt.pc);
    assign wr_rec.inst  = cmt.inst;
    assign wr_rec.rd    = cmt.rd;
    assign wr_rec.wen   = rd_writes(cmt.wen, cmt.rd);
    assign wr_rec.wdata = REC_XLEN'(cmt.wdata);
    assign wr_rec.skip  = cmt.skip;
    assign wr_rec.halt  = cmt.halt;

    assign trc.pc    = head.pc[XLEN-1:0];
    assign trc.inst  = head.inst;
    assign trc.rd    = head.rd;
    assign trc.wen   = head.wen;
    assign trc.wdata = head.wdata[XLEN-1:0];
    assign trc.skip  = head.skip;
    assign trc.halt  = head.halt;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (wr_rec),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (occupancy)
    );

    // Halt sequencing: stop accepting at ebreak, finish once it has been consumed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEQ_RUN;
            halt_done <= 1'b0;
            instr_cnt <= '0;
        end else begin
            if (pop) begin
                instr_cnt <= instr_cnt + XLEN'(1);
            end
            case (state)
                SEQ_RUN: begin
                    if (push && cmt.halt) begin
                        state <= SEQ_DRAIN;
                    end
                end
                SEQ_DRAIN: begin
                    if (pop && head.halt) begin
                        state     <= SEQ_HALTED;
                        halt_done <= 1'b1;
                    end
                end
                SEQ_HALTED: begin
                    halt_done <= 1'b1;
                end
                default: begin
                    state <= SEQ_RUN;
                end
            endcase
        end
    end

endmodule
